otter_pc_fetch: RTL and testbench
=================================

# otter_pc_fetch

Program-counter and instruction-fetch stage of the OTTER core. Holds the architectural PC, selects the next PC from the branch/jump targets produced by the address generator (JAL, BRANCH, JALR) plus trap vectors, and fetches each instruction through a request/grant/valid handshake to instruction memory. It presents one instruction at a time to the control unit and counts retired instructions.

## Interface
- RESET_VEC, 32'h0000_0000, PC value loaded on reset
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- PC_SOURCE  in  3  next-PC select: 0 PC+4, 1 JALR, 2 BRANCH, 3 JAL, 4 MTVEC, 5 MEPC, 6/7 treated as 0
- JAL, BRANCH, JALR  in  32 each  jump/branch targets from the address generator
- MTVEC, MEPC  in  32 each  trap vector and exception return address
- PC_WRITE  in  1  control unit retires the current instruction and commits the next PC
- IMEM_REQ  out  1  fetch request
- IMEM_ADDR  out  32  fetch address (equals PC)
- IMEM_GNT  in  1  memory accepts the request this cycle
- IMEM_RVALID  in  1  read data valid
- IMEM_RDATA  in  32  fetched instruction word
- INSTR  out  32  held instruction
- INSTR_VALID  out  1  INSTR is valid for the current PC
- PC  out  32  current PC
- PC_PLUS4  out  32  PC + 4, combinational, modulo 2^32
- MISALIGN  out  1  one-cycle pulse: rejected target not word-aligned
- INSTRET  out  32  retired-instruction counter

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: entered only from reset. Moves to REQ unconditionally on the next edge.
- REQ: IMEM_REQ=1, IMEM_ADDR=PC.
  - On IMEM_GNT=1 with IMEM_RVALID=0, go to WAIT.
  - On IMEM_GNT=1 with IMEM_RVALID=1 (zero-latency memory), capture IMEM_RDATA into INSTR and go to HOLD.
  - IMEM_RVALID without IMEM_GNT is a stale response. Ignore it.
- WAIT: IMEM_REQ=0. On IMEM_RVALID, capture INSTR and go to HOLD.
- HOLD: INSTR_VALID=1 and INSTR is stable. On PC_WRITE=1, compute target = mux(PC_SOURCE).
  - target[1:0]==0: PC<=target, INSTRET<=INSTRET+1 (wraps at 2^32), INSTR_VALID<=0, go to REQ.
  - target[1:0]!=0: PC, INSTR and INSTRET are unchanged. MISALIGN=1 for the next cycle. Stay in HOLD. The control unit is expected to follow with PC_SOURCE=4 (MTVEC).
- PC_WRITE outside HOLD is ignored. There is no PC change and no count.
- IMEM_RVALID in IDLE/HOLD is ignored.
- IMEM_ADDR is driven with PC in every state. It is only meaningful while IMEM_REQ=1.
- Adders are 32-bit unsigned and wrap: PC=32'hFFFF_FFFC gives PC_PLUS4=0.

## Timing
- Reset values (asynchronous, while RST_N=0):
  - state IDLE, PC=RESET_VEC
  - INSTR=0, INSTR_VALID=0, IMEM_REQ=0
  - MISALIGN=0, INSTRET=0
- Reset assertion mid-fetch aborts immediately. Any later response is discarded under the REQ rule above.
- IMEM_REQ is high from the first cycle after the first rising edge following RST_N deassertion.
- IMEM_REQ and IMEM_ADDR are held stable until IMEM_GNT.
- Minimum instruction period is 3 cycles with one-cycle-latency memory:
  - c0: REQ, GNT
  - c1: WAIT, RVALID
  - c2: HOLD, INSTR_VALID=1, PC_WRITE
  - c3: REQ with the new PC
- Minimum is 2 cycles with zero-latency memory.
- INSTR_VALID rises the cycle after the capturing edge. It falls the cycle after an accepted PC_WRITE.
- PC, INSTRET and MISALIGN are registered and update on the PC_WRITE edge.
- PC_PLUS4 follows PC combinationally.

## Test plan
- Reset/sequential: RESET_VEC=0x100, 1-cycle memory, PC_SOURCE=0, PC_WRITE in every HOLD. IMEM_ADDR must go 0x100, 0x104, 0x108 at 3-cycle spacing, and INSTRET must be 3 after the third retire.
- Target select: in HOLD with JAL=0x200, BRANCH=0x300, JALR=0x400, MTVEC=0x40, MEPC=0x80, step PC_SOURCE through 1..5 and then 7. The next fetch addresses must be 0x400, 0x300, 0x200, 0x40, 0x80, and then PC+4.
- Stalled memory: hold IMEM_GNT low for 4 cycles, then RVALID 3 cycles after grant. IMEM_REQ and IMEM_ADDR must stay constant until grant, INSTR_VALID must stay 0 until the cycle after RVALID, and an injected RVALID without GNT during REQ must be ignored.
- Misalign: JALR=0x202, PC_SOURCE=1, PC_WRITE. Required: a MISALIGN pulse of one cycle, PC unchanged, INSTRET unchanged, and still in HOLD. Then PC_SOURCE=4 with PC_WRITE must fetch from MTVEC.
- Wrap: RESET_VEC=0xFFFF_FFFC, PC_SOURCE=0, PC_WRITE. Required: PC_PLUS4=0 and the next IMEM_ADDR=0. With INSTRET forced/preloaded to 0xFFFF_FFFF, the count must wrap to 0.
- Reset mid-operation: drop RST_N during WAIT, release, then present a stale RVALID before any GNT. Required: outputs at reset values, the stale data not captured, and the fetch restarting at RESET_VEC.

Source files
------------

// File: rtl/otter_pc_fetch.sv
// otter_pc_fetch: architectural PC, next-PC select and req/gnt/rvalid instruction fetch.
// INSTRET_INIT lets an instance start the retire counter elsewhere than zero.
module otter_pc_fetch #(
  parameter logic [31:0] RESET_VEC    = 32'h0000_0000,
  parameter logic [31:0] INSTRET_INIT = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [2:0]  pc_source_i,
  input  logic [31:0] jal_i,
  input  logic [31:0] branch_i,
  input  logic [31:0] jalr_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic        pc_write_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        misalign_o,
  output logic [31:0] instret_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, instret_q, instret_d, target;
  logic        req_q, valid_q, mis_q, mis_d;
  assign pc_plus4_o    = pc_q + 32'd4;
  assign pc_o          = pc_q;
  assign imem_addr_o   = pc_q;
  assign imem_req_o    = req_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign misalign_o    = mis_q;
  assign instret_o     = instret_q;
  always_comb
    target = pc_source_i == 3'd1 ? jalr_i   :
             pc_source_i == 3'd2 ? branch_i :
             pc_source_i == 3'd3 ? jal_i    :
             pc_source_i == 3'd4 ? mtvec_i  :
             pc_source_i == 3'd5 ? mepc_i   : pc_plus4_o;
  // Responses without a grant in REQ, and any response in IDLE/HOLD, are stale.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    mis_d     = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: if (imem_gnt_i) begin
        state_d = imem_rvalid_i ? HOLD : WAIT;
        instr_d = imem_rvalid_i ? imem_rdata_i : instr_q;
      end
      WAIT: if (imem_rvalid_i) begin
        state_d = HOLD;
        instr_d = imem_rdata_i;
      end
      HOLD: if (pc_write_i) begin
        if (target[1:0] == 2'b00) begin
          pc_d      = target;
          instret_d = instret_q + 32'd1;
          state_d   = REQ;
        end else mis_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q   <= IDLE;
      pc_q      <= RESET_VEC;
      instr_q   <= '0;
      instret_q <= INSTRET_INIT;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      req_q     <= state_d == REQ;
      valid_q   <= state_d == HOLD;
      mis_q     <= mis_d;
    end
endmodule

// File: tb/tb_otter_pc_fetch.sv
// tb_otter_pc_fetch: randomized fetch/retire traffic against a queue-based PC model.
module tb_otter_pc_fetch;
  localparam logic [31:0] RV = 32'h0000_0100;
  typedef struct packed {logic [31:0] a; logic [31:0] n;} exp_t;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic [2:0]  src = '0;
  logic [31:0] jal = '0, branch = '0, jalr = '0, mtvec = '0, mepc = '0, rdata = '0;
  logic        pw = 1'b0, gnt = 1'b0, rv = 1'b0;
  logic        req, valid, mis;
  logic [31:0] addr, instr, pc, pc4, cnt;
  logic        w_pw = 1'b0, w_gnt = 1'b0, w_rv = 1'b0;
  logic [31:0] w_rdata = '0;
  logic        w_req, w_valid, w_mis;
  logic [31:0] w_addr, w_instr, w_pc, w_pc4, w_cnt;
  int          n_chk = 0, n_fail = 0, cyc = 0;
  exp_t        exp_q[$];
  int          mis_q[$];
  logic [31:0] m_pc = RV, m_cnt = '0;
  always #5 clk = ~clk;
  otter_pc_fetch #(.RESET_VEC(RV)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .pc_source_i(src), .jal_i(jal), .branch_i(branch),
    .jalr_i(jalr), .mtvec_i(mtvec), .mepc_i(mepc), .pc_write_i(pw), .imem_req_o(req),
    .imem_addr_o(addr), .imem_gnt_i(gnt), .imem_rvalid_i(rv), .imem_rdata_i(rdata),
    .instr_o(instr), .instr_valid_o(valid), .pc_o(pc), .pc_plus4_o(pc4),
    .misalign_o(mis), .instret_o(cnt));
  otter_pc_fetch #(.RESET_VEC(32'hFFFF_FFFC), .INSTRET_INIT(32'hFFFF_FFFF)) u_wrap (
    .clk_i(clk), .rst_ni(rst_n), .pc_source_i(3'd0), .jal_i(32'h0), .branch_i(32'h0),
    .jalr_i(32'h0), .mtvec_i(32'h0), .mepc_i(32'h0), .pc_write_i(w_pw), .imem_req_o(w_req),
    .imem_addr_o(w_addr), .imem_gnt_i(w_gnt), .imem_rvalid_i(w_rv), .imem_rdata_i(w_rdata),
    .instr_o(w_instr), .instr_valid_o(w_valid), .pc_o(w_pc), .pc_plus4_o(w_pc4),
    .misalign_o(w_mis), .instret_o(w_cnt));
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask
  task automatic miss(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event did not occur as required", nm);
  endtask
  // Monitor: compares fetch addresses and captured instructions against the scoreboard.
  logic p_req = 0, p_gnt = 0, p_rv = 0, p_valid = 0, exp_m;
  logic [31:0] p_addr = '0;
  exp_t e;
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      p_req = 0; p_gnt = 0; p_rv = 0; p_valid = 0;
    end else begin
      if (p_req && !p_gnt) begin
        chk("req_hold", {31'b0, req}, 32'd1);
        chk("addr_hold", addr, p_addr);
      end
      if (req && gnt) begin
        if (exp_q.size() == 0) miss("grant_without_expected_fetch");
        else chk("fetch_addr", addr, exp_q[0].a);
      end
      if (valid && !p_valid) begin
        chk("valid_after_rvalid", {31'b0, p_rv}, 32'd1);
        if (exp_q.size() == 0) miss("valid_without_expected_fetch");
        else begin
          e = exp_q.pop_front();
          chk("instr", instr, memf(e.a));
          chk("pc", pc, e.a);
          chk("pc_plus4", pc4, e.a + 32'd4);
          chk("instret", cnt, e.n);
        end
      end
      exp_m = mis_q.size() > 0 && mis_q[0] == cyc;
      if (mis || exp_m) begin
        if (exp_m) void'(mis_q.pop_front());
        chk("misalign", {31'b0, mis}, {31'b0, exp_m});
      end
      p_req = req; p_gnt = gnt; p_rv = rv; p_valid = valid; p_addr = addr;
    end
    cyc++;
  end
  task automatic serve(input int gd, input int lat, input bit stale, output int gc);
    logic [31:0] ga;
    int t = 0;
    gc = 0;
    while (!req && t < 20) begin @(negedge clk); t++; end
    if (!req) begin miss("req_timeout"); return; end
    for (int i = 0; i < gd; i++) begin
      rv = stale && i == 0;
      rdata = 32'hDEAD_BEEF;
      pw = 1'($urandom);
      src = 3'($urandom);
      @(negedge clk);
    end
    gc = cyc;
    ga = addr;
    rv = 1'b0;
    pw = 1'($urandom);
    gnt = 1'b1;
    if (lat == 0) begin rv = 1'b1; rdata = memf(ga); end
    @(negedge clk);
    gnt = 1'b0; rv = 1'b0; pw = 1'b0;
    if (lat > 0) begin
      repeat (lat - 1) begin pw = 1'($urandom); @(negedge clk); end
      pw = 1'b0; rv = 1'b1; rdata = memf(ga);
      @(negedge clk);
      rv = 1'b0;
    end
  endtask
  task automatic retire(input logic [2:0] s, input bit junk, output bit ok);
    logic [31:0] tg;
    logic [31:0] tgt [8];
    int t = 0;
    ok = 1'b0;
    while (!valid && t < 20) begin @(negedge clk); t++; end
    if (!valid) begin miss("valid_timeout"); return; end
    if (junk) begin rv = 1'b1; rdata = 32'hBAD0_BAD0; @(negedge clk); rv = 1'b0; end
    chk("instr_hold", instr, memf(m_pc));
    tgt = '{m_pc + 32'd4, jalr, branch, jal, mtvec, mepc, m_pc + 32'd4, m_pc + 32'd4};
    tg = tgt[s];
    ok = tg[1:0] == 2'b00;
    src = s;
    pw = 1'b1;
    if (ok) begin
      m_pc = tg;
      m_cnt = m_cnt + 32'd1;
      exp_q.push_back('{a: tg, n: m_cnt});
    end else mis_q.push_back(cyc + 1);
    @(negedge clk);
    pw = 1'b0;
    chk("pc_after_write", pc, m_pc);
    chk("instret_after_write", cnt, m_cnt);
    chk("valid_after_write", {31'b0, valid}, ok ? 32'd0 : 32'd1);
  endtask
  function automatic logic [31:0] rnd_tgt();
    logic [31:0] v = $urandom;
    if ($urandom_range(0, 7) != 0) v[1:0] = 2'b00;
    return v;
  endfunction
  int g0, g1, g2;
  bit ok;
  logic [2:0] sel [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, req}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", pc, RV);
    chk("rst_instret", cnt, 32'd0);
    chk("rst_misalign", {31'b0, mis}, 32'd0);
    chk("rst_pc_plus4", pc4, RV + 32'd4);
    chk("wrap_pc_plus4", w_pc4, 32'd0);
    exp_q.push_back('{a: RV, n: 32'd0});
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_first_cycle", {31'b0, req}, 32'd1);
    // counter and PC wrap on the preloaded instance
    for (int t = 0; t < 5 && !w_req; t++) @(negedge clk);
    chk("wrap_req", {31'b0, w_req}, 32'd1);
    w_gnt = 1'b1; w_rv = 1'b1; w_rdata = 32'h0000_0013;
    @(negedge clk);
    w_gnt = 1'b0; w_rv = 1'b0;
    chk("wrap_valid", {31'b0, w_valid}, 32'd1);
    w_pw = 1'b1;
    @(negedge clk);
    w_pw = 1'b0;
    chk("wrap_pc", w_pc, 32'd0);
    chk("wrap_instret", w_cnt, 32'd0);
    chk("wrap_addr", w_addr, 32'd0);
    chk("wrap_req_next", {31'b0, w_req}, 32'd1);
    serve(0, 1, 0, g0); retire(0, 0, ok);
    serve(0, 1, 0, g1); retire(0, 0, ok);
    serve(0, 1, 0, g2); retire(0, 0, ok);
    chk("spacing_1lat_a", g1 - g0, 32'd3);
    chk("spacing_1lat_b", g2 - g1, 32'd3);
    chk("instret_after_3", cnt, 32'd3);
    serve(0, 0, 0, g0); retire(0, 0, ok);
    serve(0, 0, 0, g1); retire(0, 0, ok);
    chk("spacing_0lat", g1 - g0, 32'd2);
    jal = 32'h200; branch = 32'h300; jalr = 32'h400; mtvec = 32'h40; mepc = 32'h80;
    foreach (sel[i]) begin serve(0, 1, 0, g0); retire(sel[i], 0, ok); end
    serve(4, 3, 1, g0); retire(0, 0, ok);
    serve(0, 1, 0, g0);
    jalr = 32'h202;
    retire(1, 0, ok);
    chk("misalign_rejected", {31'b0, ok}, 32'd0);
    retire(4, 0, ok);
    serve(0, 1, 0, g0);
    chk("trap_pc", pc, 32'h40);
    jal = 32'hFFFF_FFFC;
    retire(3, 0, ok);
    serve(0, 2, 0, g0);
    chk("pc_plus4_wrap", pc4, 32'd0);
    retire(0, 0, ok);
    for (int i = 0; i < 40; i++) begin
      serve($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), g0);
      jal = rnd_tgt(); branch = rnd_tgt(); jalr = rnd_tgt(); mepc = rnd_tgt();
      mtvec = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      retire(3'($urandom_range(0, 7)), 1'($urandom), ok);
      if (!ok) retire(4, 0, ok);
    end
    // reset while waiting on memory, then a stale response before any grant
    for (int t = 0; t < 20 && !req; t++) @(negedge clk);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'b0, req}, 32'd0);
    chk("midrst_valid", {31'b0, valid}, 32'd0);
    chk("midrst_instr", instr, 32'd0);
    chk("midrst_pc", pc, RV);
    chk("midrst_instret", cnt, 32'd0);
    chk("midrst_misalign", {31'b0, mis}, 32'd0);
    exp_q.delete();
    mis_q.delete();
    m_pc = RV;
    m_cnt = '0;
    exp_q.push_back('{a: RV, n: 32'd0});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_req", {31'b0, req}, 32'd1);
    chk("restart_addr", addr, RV);
    rv = 1'b1; rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rv = 1'b0;
    chk("stale_valid", {31'b0, valid}, 32'd0);
    chk("stale_instr", instr, 32'd0);
    serve(0, 1, 0, g0); retire(0, 0, ok);
    serve(2, 2, 1, g0);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
